// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: ALU results take priority, loads wait in a
// 4-entry FIFO whose entries are squashed by younger ALU writes to the same rd.
module writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        RegWrite,
  output logic [4:0]  Rd,
  output logic [31:0] Write_data,
  output logic [2:0]  q_count,
  output logic [15:0] wr_count
);

  logic [4:0]  rd_r   [4];
  logic [31:0] data_r [4];
  logic [3:0]  live_r;
  logic [1:0]  head_r;
  logic [1:0]  tail_r;
  logic [2:0]  count_r;

  logic        alu_sel_s;
  logic        pop_s;
  logic        push_s;
  logic        commit_s;
  logic [4:0]  wb_rd_s;
  logic [31:0] wb_data_s;

  assign q_count  = count_r;
  assign ld_ready = (count_r < 3'd4) && !rst;

  // Write-port arbitration and FIFO handshake decode.
  always_comb begin
    alu_sel_s = alu_valid && (alu_rd != 5'd0);
    pop_s     = !alu_sel_s && (count_r != 3'd0);
    push_s    = ld_valid && ld_ready && (ld_rd != 5'd0);
    if (alu_sel_s) begin
      commit_s  = 1'b1;
      wb_rd_s   = alu_rd;
      wb_data_s = alu_data;
    end else if (pop_s) begin
      // A squashed head is still popped but does not write.
      commit_s  = live_r[head_r];
      wb_rd_s   = rd_r[head_r];
      wb_data_s = data_r[head_r];
    end else begin
      commit_s  = 1'b0;
      wb_rd_s   = 5'd0;
      wb_data_s = 32'd0;
    end
  end

  // Load FIFO storage, pointers, occupancy and squash.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= 2'd0;
      tail_r  <= 2'd0;
      count_r <= 3'd0;
      live_r  <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        rd_r[i]   <= 5'd0;
        data_r[i] <= 32'd0;
      end
    end else begin
      // Free slots always hold live=0, so matching across all slots only hits queued entries.
      for (int i = 0; i < 4; i++) begin
        if (alu_sel_s && (rd_r[i] == alu_rd)) begin
          live_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        live_r[head_r] <= 1'b0;
        head_r         <= head_r + 2'd1;
      end
      // The new entry is younger than the ALU write, so it overrides the squash above.
      if (push_s) begin
        rd_r[tail_r]   <= ld_rd;
        data_r[tail_r] <= ld_data;
        live_r[tail_r] <= 1'b1;
        tail_r         <= tail_r + 2'd1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered register-file write port and commit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite   <= 1'b0;
      Rd         <= 5'd0;
      Write_data <= 32'd0;
      wr_count   <= 16'd0;
    end else if (commit_s) begin
      RegWrite   <= 1'b1;
      Rd         <= wb_rd_s;
      Write_data <= wb_data_s;
      wr_count   <= wr_count + 16'd1;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
  logic [2:0]  q_count;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  writeback_unit dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data),
    .q_count(q_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input string tag, input logic we, input logic [4:0] r,
                    input logic [31:0] d, input logic [2:0] q, input logic [15:0] wc);
    chk({tag, ".RegWrite"}, {31'd0, RegWrite}, {31'd0, we});
    chk({tag, ".Rd"}, {27'd0, Rd}, {27'd0, r});
    chk({tag, ".Write_data"}, Write_data, d);
    chk({tag, ".q_count"}, {29'd0, q_count}, {29'd0, q});
    chk({tag, ".wr_count"}, {16'd0, wr_count}, {16'd0, wc});
  endtask

  task automatic alu(input logic v, input logic [4:0] r, input logic [31:0] d);
    alu_valid = v; alu_rd = r; alu_data = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] r, input logic [31:0] d);
    ld_valid = v; ld_rd = r; ld_data = d;
  endtask

  initial begin
    rst = 1'b1;
    alu(1'b0, 5'd0, 32'd0);
    ld(1'b0, 5'd0, 32'd0);
    step(); step();
    wb("reset", 1'b0, 5'd0, 32'd0, 3'd0, 16'd0);
    chk("reset.ld_ready", {31'd0, ld_ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_reset.ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("post_reset.RegWrite", {31'd0, RegWrite}, 32'd0);

    // ALU write with 1-cycle latency, then hold when idle
    alu(1'b1, 5'd5, 32'hDEADBEEF);
    step(); wb("alu5", 1'b1, 5'd5, 32'hDEADBEEF, 3'd0, 16'd1);
    alu(1'b0, 5'd0, 32'd0);
    step(); wb("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF, 3'd0, 16'd1);

    // Loads stream through in order with ALU idle
    for (int i = 1; i <= 5; i++) begin
      ld(1'b1, 5'(i), 32'h10 + 32'(i - 1));
      step();
      if (i == 1) wb("ld_first", 1'b0, 5'd5, 32'hDEADBEEF, 3'd1, 16'd1);
      else wb($sformatf("ld_seq%0d", i - 1), 1'b1, 5'(i - 1), 32'h10 + 32'(i - 2), 3'd1, 16'(i));
    end
    ld(1'b0, 5'd0, 32'd0);
    step(); wb("ld_seq5", 1'b1, 5'd5, 32'h14, 3'd0, 16'd6);

    // Loads starve behind continuous ALU traffic, drain after
    alu(1'b1, 5'd9, 32'h900);
    ld(1'b1, 5'd7, 32'h70);
    step(); wb("starve1", 1'b1, 5'd9, 32'h900, 3'd1, 16'd7);
    ld(1'b1, 5'd8, 32'h80);
    step(); wb("starve2", 1'b1, 5'd9, 32'h900, 3'd2, 16'd8);
    ld(1'b0, 5'd0, 32'd0);
    step(); wb("starve3", 1'b1, 5'd9, 32'h900, 3'd2, 16'd9);
    alu(1'b0, 5'd0, 32'd0);
    step(); wb("drain7", 1'b1, 5'd7, 32'h70, 3'd1, 16'd10);
    step(); wb("drain8", 1'b1, 5'd8, 32'h80, 3'd0, 16'd11);

    // Fill to 4 entries: ld_ready drops, no entry is lost, wrap-around order held
    alu(1'b1, 5'd9, 32'h901);
    for (int i = 0; i < 4; i++) begin
      ld(1'b1, 5'd10 + 5'(i), 32'h100 + 32'(i));
      step();
    end
    wb("full", 1'b1, 5'd9, 32'h901, 3'd4, 16'd15);
    ld(1'b1, 5'd14, 32'h1FF);
    #1 chk("full.ld_ready", {31'd0, ld_ready}, 32'd0);
    step(); wb("full_hold", 1'b1, 5'd9, 32'h901, 3'd4, 16'd16);
    ld(1'b0, 5'd0, 32'd0);
    alu(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      wb($sformatf("full_drain%0d", i), 1'b1, 5'd10 + 5'(i), 32'h100 + 32'(i), 3'(3 - i), 16'd17 + 16'(i));
    end
    chk("drained.ld_ready", {31'd0, ld_ready}, 32'd1);

    // Squash: queued load to rd6 overtaken by ALU write to rd6
    alu(1'b1, 5'd9, 32'h902);
    ld(1'b1, 5'd6, 32'h60);
    step(); wb("sq_queue", 1'b1, 5'd9, 32'h902, 3'd1, 16'd21);
    alu(1'b1, 5'd6, 32'hAAAA);
    ld(1'b0, 5'd0, 32'd0);
    step(); wb("sq_alu6", 1'b1, 5'd6, 32'hAAAA, 3'd1, 16'd22);
    alu(1'b0, 5'd0, 32'd0);
    step(); wb("sq_pop_dead", 1'b0, 5'd6, 32'hAAAA, 3'd0, 16'd22);
    step(); wb("sq_idle", 1'b0, 5'd6, 32'hAAAA, 3'd0, 16'd22);

    // Same-cycle load to the ALU's rd is younger and survives
    alu(1'b1, 5'd3, 32'h33);
    ld(1'b1, 5'd3, 32'h44);
    step(); wb("young_alu", 1'b1, 5'd3, 32'h33, 3'd1, 16'd23);
    alu(1'b0, 5'd0, 32'd0);
    ld(1'b0, 5'd0, 32'd0);
    step(); wb("young_ld", 1'b1, 5'd3, 32'h44, 3'd0, 16'd24);

    // rd0 on both sources: nothing written, handshake still accepted
    alu(1'b1, 5'd0, 32'h55);
    ld(1'b1, 5'd0, 32'h66);
    step(); wb("rd0", 1'b0, 5'd3, 32'h44, 3'd0, 16'd24);
    chk("rd0.ld_ready", {31'd0, ld_ready}, 32'd1);

    // ALU to rd0 leaves the port free for the FIFO head
    alu(1'b1, 5'd9, 32'h99);
    ld(1'b1, 5'd2, 32'h22);
    step(); wb("rd0drain_q", 1'b1, 5'd9, 32'h99, 3'd1, 16'd25);
    alu(1'b1, 5'd0, 32'h77);
    ld(1'b0, 5'd0, 32'd0);
    step(); wb("rd0drain", 1'b1, 5'd2, 32'h22, 3'd0, 16'd26);

    // Reset with q_count=3 and a write in flight
    alu(1'b1, 5'd9, 32'h9A);
    for (int i = 1; i <= 3; i++) begin
      ld(1'b1, 5'(i), 32'h200 + 32'(i));
      step();
    end
    wb("pre_rst", 1'b1, 5'd9, 32'h9A, 3'd3, 16'd29);
    rst = 1'b1;
    #1 chk("rst.ld_ready_comb", {31'd0, ld_ready}, 32'd0);
    step(); wb("rst", 1'b0, 5'd0, 32'd0, 3'd0, 16'd0);
    chk("rst.ld_ready", {31'd0, ld_ready}, 32'd0);
    rst = 1'b0;
    alu(1'b0, 5'd0, 32'd0);
    ld(1'b0, 5'd0, 32'd0);
    #1 chk("after_rst.ld_ready", {31'd0, ld_ready}, 32'd1);
    step(); wb("after_rst", 1'b0, 5'd0, 32'd0, 3'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-002 Port clk, input, 1: rising-edge clock.
REQ-003 Port rst, input, 1: synchronous active-high reset.
REQ-004 Port alu_valid, input, 1: ALU result present this cycle; no backpressure.
REQ-005 Port alu_rd, input, 5: ALU destination register.
REQ-006 Port alu_data, input, 32: ALU result.
REQ-007 Port ld_valid, input, 1: load result offered.
REQ-008 Port ld_ready, output, 1: load result accepted when ld_valid && ld_ready.
REQ-009 Port ld_rd, input, 5: load destination register.
REQ-010 Port ld_data, input, 32: load result.
REQ-011 Port RegWrite, output, 1: register-file write enable; registered.
REQ-012 Port Rd, output, 5: register-file write index; registered.
REQ-013 Port Write_data, output, 32: register-file write data; registered.
REQ-014 Port q_count, output, 3: load FIFO occupancy, 0..4.
REQ-015 Port wr_count, output, 16: committed write counter.

Function
REQ-016 The load FIFO SHALL be 4 entries deep; each entry holds rd[4:0], data[31:0] and a live bit.
REQ-017 ld_ready SHALL be (q_count < 4) && !rst, combinationally.
REQ-018 A load handshake with ld_rd != 0 SHALL enqueue a live entry at the tail; a handshake with ld_rd == 0 SHALL be accepted and discarded.
REQ-019 Each cycle, write-port selection SHALL be: ALU first if alu_valid && alu_rd != 0; otherwise the FIFO head if q_count > 0; otherwise idle.
REQ-020 The selected source SHALL appear on Rd/Write_data with RegWrite=1 on the next rising edge, giving 1-cycle latency.
REQ-021 An ALU result with alu_rd == 0 SHALL be dropped, SHALL not take the port, and SHALL leave the FIFO free to drain that cycle.
REQ-022 When no write is committed, RegWrite SHALL be 0, and Rd/Write_data SHALL hold their previous values.
REQ-023 When an ALU write to rd X is committed, every FIFO entry with rd == X that exists at that edge SHALL have its live bit cleared (squash), so that an older load never overwrites a younger ALU result.
REQ-024 A load enqueued in the same cycle as an ALU write to the same rd SHALL NOT be squashed, because the load is younger.
REQ-025 When a dead (squashed) head is selected, it SHALL be popped with RegWrite=0 and SHALL consume that cycle.
REQ-026 A simultaneous enqueue and pop SHALL leave q_count unchanged; the FIFO pointers SHALL be 2-bit and wrap modulo 4.
REQ-027 FIFO order SHALL be preserved; loads SHALL never reorder among themselves.
REQ-028 Loads MAY starve under continuous ALU traffic; ld_ready then deasserts at q_count == 4, and no entry is lost.
REQ-029 wr_count SHALL increment by 1 on every cycle in which RegWrite is asserted, and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-030 While rst=1 at a rising edge, the block SHALL set RegWrite=0, Rd=0, Write_data=0, q_count=0, wr_count=0, clear the pointers, and clear all live bits.
REQ-031 Reset SHALL override any concurrent handshake; an in-flight load offered during reset SHALL not be accepted because ld_ready=0.
REQ-032 On the first edge after rst falls, the block SHALL operate normally from an empty state.

Verification
REQ-033 ALU alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF -> next cycle RegWrite=1, Rd=5, Write_data=32'hDEADBEEF, and wr_count=1.
REQ-034 Four load handshakes (rd=1..4, data=32'h10..32'h13) with ALU idle, followed by a fifth offered load -> writes occur in order rd 1,2,3,4 on consecutive cycles; ld_ready=0 only while q_count=4.
REQ-035 Fill the FIFO with loads rd=7,8 while ALU is continuously valid to rd=9 for 3 cycles -> the loads stay queued (q_count=2) and drain the 2 cycles after the ALU goes idle.
REQ-036 Load rd=6 is queued, then ALU writes rd=6 with 32'hAAAA -> the load entry is squashed; its pop shows RegWrite=0; the final value written to rd 6 is 32'hAAAA; wr_count increments only once.
REQ-037 ALU alu_rd=0 and load ld_rd=0 -> no RegWrite; ld_ready stays 1, and q_count stays 0.
REQ-038 Assert rst with q_count=3 and RegWrite=1 -> next cycle all outputs are 0, and ld_ready=0 during reset and 1 after.
